// File: rtl/lc3_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : lc3_mem_responder_if
// Description : Bus bundle between the LC3 core side and lc3_mem_responder.
//               Carries the fetch port, the data port and a word-load port
//               used by the environment to preload either memory array.
// Revision    : 1.0 - initial release
// ============================================================================
interface lc3_mem_responder_if;
  // Fetch port
  logic [15:0] pc;
  logic        instrmem_rd;
  logic [15:0] Instr_dout;
  logic        complete_instr;
  // Data port
  logic        data_req;
  logic        Data_rd;
  logic [15:0] Data_addr;
  logic [15:0] Data_din;
  logic [15:0] Data_dout;
  logic        complete_data;
  // Array preload port (shared address/data, one enable per array)
  logic        load_imem_we;
  logic        load_dmem_we;
  logic [15:0] load_addr;
  logic [15:0] load_data;

  modport master (
    output pc, instrmem_rd, data_req, Data_rd, Data_addr, Data_din,
           load_imem_we, load_dmem_we, load_addr, load_data,
    input  Instr_dout, complete_instr, Data_dout, complete_data
  );

  modport slave (
    input  pc, instrmem_rd, data_req, Data_rd, Data_addr, Data_din,
           load_imem_we, load_dmem_we, load_addr, load_data,
    output Instr_dout, complete_instr, Data_dout, complete_data
  );
endinterface
`default_nettype wire

// File: rtl/lc3_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : lc3_mem_responder
// Description : Instruction/data memory model for the LC3 external memory
//               interface. Two independent ports, each an IDLE/BUSY FSM with
//               a wait-state down-counter; completion is a registered
//               one-cycle pulse. Optional macro LC3_MEM_RAND_WAIT_EN adds
//               0..3 pseudo-random extra wait cycles per access.
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_mem_responder #(
  parameter int ADDR_W     = 10,
  parameter int INSTR_WAIT = 0,
  parameter int DATA_WAIT  = 1
) (
  input wire logic           clock,
  input wire logic           reset,
  lc3_mem_responder_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef LC3_MEM_RAND_WAIT_EN
  // One extra bit so WAIT + extra never wraps.
  localparam int CNT_W = 5;
`else
  localparam int CNT_W = 4;
`endif
  localparam logic [CNT_W-1:0] C_IWAIT   = CNT_W'(INSTR_WAIT);
  localparam logic [CNT_W-1:0] C_DWAIT   = CNT_W'(DATA_WAIT);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Backing storage; not touched by reset.
  logic [15:0] r_imem [DEPTH];
  logic [15:0] r_dmem [DEPTH];

  // Fetch port state
  state_t            r_i_state;
  logic [CNT_W-1:0]  r_i_cnt;
  logic [ADDR_W-1:0] r_i_addr;
  logic              r_complete_instr;
  logic [15:0]       r_instr_dout;

  // Data port state
  state_t            r_d_state;
  logic [CNT_W-1:0]  r_d_cnt;
  logic [ADDR_W-1:0] r_d_addr;
  logic              r_d_rd;
  logic [15:0]       r_d_din;
  logic              r_complete_data;
  logic [15:0]       r_data_dout;

  logic             w_i_done;
  logic             w_i_accept;
  logic [CNT_W-1:0] w_i_load;
  logic             w_d_done;
  logic             w_d_accept;
  logic [CNT_W-1:0] w_d_load;
  logic             w_d_wr_fire;
  logic             w_unused;

  // A port completes on the edge where it is BUSY with the counter at zero;
  // that same edge may accept the next request.
  assign w_i_done    = (r_i_state == ST_BUSY) && (r_i_cnt == '0);
  assign w_i_accept  = bus.instrmem_rd && ((r_i_state == ST_IDLE) || w_i_done);
  assign w_d_done    = (r_d_state == ST_BUSY) && (r_d_cnt == '0);
  assign w_d_accept  = bus.data_req && ((r_d_state == ST_IDLE) || w_d_done);
  assign w_d_wr_fire = w_d_done && !r_d_rd;

  // Upper address bits alias and are intentionally ignored.
  assign w_unused = &{1'b0, bus.pc[15:ADDR_W], bus.Data_addr[15:ADDR_W],
                      bus.load_addr[15:ADDR_W]};

`ifdef LC3_MEM_RAND_WAIT_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Free-running Fibonacci LFSR supplying the extra wait cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  assign w_i_load = C_IWAIT + {{(CNT_W-2){1'b0}}, r_lfsr[1:0]};
  assign w_d_load = C_DWAIT + {{(CNT_W-2){1'b0}}, r_lfsr[3:2]};
`else
  assign w_i_load = C_IWAIT;
  assign w_d_load = C_DWAIT;
`endif

  // Instruction array preload.
  always_ff @(posedge clock) begin
    if (bus.load_imem_we) begin
      r_imem[bus.load_addr[ADDR_W-1:0]] <= bus.load_data;
    end
  end

  // Data array: preload plus write completions (a reset edge aborts writes).
  always_ff @(posedge clock) begin
    if (bus.load_dmem_we) begin
      r_dmem[bus.load_addr[ADDR_W-1:0]] <= bus.load_data;
    end
    if (!reset && w_d_wr_fire) begin
      r_dmem[r_d_addr] <= r_d_din;
    end
  end

  // Fetch port FSM with registered completion pulse and read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_i_state        <= ST_IDLE;
      r_i_cnt          <= '0;
      r_i_addr         <= '0;
      r_complete_instr <= 1'b0;
      r_instr_dout     <= 16'h0000;
    end else begin
      r_complete_instr <= w_i_done;
      if (w_i_done) begin
        r_instr_dout <= r_imem[r_i_addr];
      end
      if (w_i_accept) begin
        r_i_addr  <= bus.pc[ADDR_W-1:0];
        r_i_cnt   <= w_i_load;
        r_i_state <= ST_BUSY;
      end else if (w_i_done) begin
        r_i_state <= ST_IDLE;
      end else if (r_i_state == ST_BUSY) begin
        r_i_cnt <= r_i_cnt - C_CNT_ONE;
      end
    end
  end

  // Data port FSM; reads update Data_dout at completion, writes leave it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_d_state       <= ST_IDLE;
      r_d_cnt         <= '0;
      r_d_addr        <= '0;
      r_d_rd          <= 1'b0;
      r_d_din         <= 16'h0000;
      r_complete_data <= 1'b0;
      r_data_dout     <= 16'h0000;
    end else begin
      r_complete_data <= w_d_done;
      if (w_d_done && r_d_rd) begin
        r_data_dout <= r_dmem[r_d_addr];
      end
      if (w_d_accept) begin
        r_d_addr  <= bus.Data_addr[ADDR_W-1:0];
        r_d_rd    <= bus.Data_rd;
        r_d_din   <= bus.Data_din;
        r_d_cnt   <= w_d_load;
        r_d_state <= ST_BUSY;
      end else if (w_d_done) begin
        r_d_state <= ST_IDLE;
      end else if (r_d_state == ST_BUSY) begin
        r_d_cnt <= r_d_cnt - C_CNT_ONE;
      end
    end
  end

  assign bus.Instr_dout     = r_instr_dout;
  assign bus.complete_instr = r_complete_instr;
  assign bus.Data_dout      = r_data_dout;
  assign bus.complete_data  = r_complete_data;

endmodule
`default_nettype wire
